ro_freq_meter: RTL and testbench
================================

RO_FREQ_METER -- requirements
Module: ro_freq_meter

Interface
REQ-001 SHALL have parameter GATE_CYCLES, default 1024, the number of clk cycles in the measurement window (>=1).
REQ-002 SHALL have parameter WARMUP_CYCLES, default 16, the number of clk cycles the ring runs before counting starts (>=1).
REQ-003 SHALL have parameter CNT_W, default 16, the width of the edge counter and of Count.
REQ-004 SHALL have parameter SYNC_STAGES, default 2, the RO_in synchronizer depth (>=2).
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all state is rising-edge triggered.
REQ-006 SHALL have port rst_n, input, 1 bit: the reset, asynchronous and active-low.
REQ-007 SHALL have port Start, input, 1 bit: the measurement request, sampled on clk.
REQ-008 SHALL have port RO_in, input, 1 bit: the ring oscillator output, asynchronous to clk.
REQ-009 SHALL have port RO_enable, output, 1 bit: the ring Enable, registered.
REQ-010 SHALL have port Count, output, CNT_W bits: the latched result of the last completed measurement.
REQ-011 SHALL have port Busy, output, 1 bit: high in WARMUP and MEASURE.
REQ-012 SHALL have port Done, output, 1 bit: high in DONE, meaning Count is valid.
REQ-013 SHALL have port Overflow, output, 1 bit: the counter-saturation flag for the last measurement (see Configuration).

Function
REQ-014 SHALL pass RO_in through a SYNC_STAGES flop synchronizer followed by one history flop; a rising edge is synchronized output = 1 while history = 0.
REQ-015 SHALL implement the FSM states IDLE, WARMUP, MEASURE and DONE.
REQ-016 SHALL, when Start = 1 is sampled in IDLE or DONE, enter WARMUP on the next cycle, clear the accumulator and the phase counter, set RO_enable = 1, and drive Done = 0.
REQ-017 SHALL stay in WARMUP for exactly WARMUP_CYCLES cycles, counting no edges, then enter MEASURE.
REQ-018 SHALL stay in MEASURE for exactly GATE_CYCLES cycles, adding 1 to the accumulator on each synchronized rising edge.
REQ-019 SHALL, on leaving MEASURE, load Count with the accumulator, including an edge detected in the final MEASURE cycle, and clear RO_enable.
REQ-020 SHALL then enter DONE, which it holds until the next Start.
REQ-021 SHALL, for Start sampled at cycle T, assert Busy from T+1, assert Done at T+1+WARMUP_CYCLES+GATE_CYCLES, and drop Busy in that same cycle.
REQ-022 SHALL ignore Start while Busy = 1; there is no abort.
REQ-023 SHALL hold Count at its previous value throughout WARMUP and MEASURE, and update it only on the MEASURE to DONE transition.
REQ-024 SHALL hold RO_enable at 0 in IDLE and DONE, so the ring is stopped while no measurement is running.
REQ-025 SHALL keep the phase counter wide enough for max(WARMUP_CYCLES, GATE_CYCLES); it SHALL not wrap within a phase.
REQ-026 SHALL assume RO_in frequency is below clk/2, with each high and low level lasting >1 clk; faster inputs alias and SHALL not be detected.

Reset
REQ-027 SHALL, on rst_n = 0 and asynchronously, force state to IDLE and clear RO_enable, Count, Busy, Done, Overflow, the accumulator, the phase counter and all synchronizer flops.
REQ-028 SHALL, if reset is asserted mid-measurement, discard the measurement with Count = 0; after release the block SHALL stay in IDLE until Start.

Configuration
REQ-029 SHALL, with macro RO_METER_SATURATE_EN defined, saturate the accumulator at 2^CNT_W-1 and set Overflow in DONE if saturation occurred; Overflow clears on the next Start.
REQ-030 SHALL, without RO_METER_SATURATE_EN, let the accumulator wrap modulo 2^CNT_W and tie Overflow to constant 0.

Verification
REQ-031 SHALL cover: reset with Start pulsed at cycle 10, WARMUP_CYCLES = 16, GATE_CYCLES = 100 -> Busy high cycles 11..126, Done = 1 at cycle 127, RO_enable low from 127.
REQ-032 SHALL cover: RO_in toggling every 5 clk while enabled, GATE_CYCLES = 100 -> Count = 10 +/-1.
REQ-033 SHALL cover: Start re-pulsed during MEASURE -> no restart and timing identical to REQ-031; Start in DONE -> new run, with Count holding its old value until completion.
REQ-034 SHALL cover: rst_n low mid-MEASURE -> all outputs 0 immediately, FSM idle after release, no Done.
REQ-035 SHALL cover: CNT_W = 4, RO_in toggling every 2 clk, GATE_CYCLES = 100 -> with the macro Count = 15 and Overflow = 1; without it Count = 25 mod 16 = 9 (+/-1) and Overflow = 0.
REQ-036 SHALL cover: RO_in held constant at 1 -> Count = 0.

Source files
------------

// File: rtl/ro_freq_meter.sv
// Ring-oscillator frequency meter.
// Enables the ring, lets it settle for WARMUP_CYCLES, then counts synchronized
// rising edges of RO_in over a GATE_CYCLES window and latches the total in Count.
// Optional build macro RO_METER_SATURATE_EN: the edge accumulator saturates at
// all-ones and Overflow reports that saturation. Without it the accumulator
// wraps and Overflow is tied low.
module ro_freq_meter #(
  parameter int GATE_CYCLES   = 1024,
  parameter int WARMUP_CYCLES = 16,
  parameter int CNT_W         = 16,
  parameter int SYNC_STAGES   = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             Start,
  input  logic             RO_in,
  output logic             RO_enable,
  output logic [CNT_W-1:0] Count,
  output logic             Busy,
  output logic             Done,
  output logic             Overflow
);

  // Phase counter only ever runs 0..max(W,G)-1, so clog2 of the longer phase suffices.
  localparam int PH_MAX = (WARMUP_CYCLES > GATE_CYCLES) ? WARMUP_CYCLES : GATE_CYCLES;
  localparam int PH_W   = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;
  localparam logic [PH_W-1:0] W_LAST = PH_W'(WARMUP_CYCLES - 1);
  localparam logic [PH_W-1:0] G_LAST = PH_W'(GATE_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, WARMUP, MEASURE, DONE} state_t;

  state_t                 state_q, state_d;
  logic [PH_W-1:0]        phase_q;
  logic [CNT_W-1:0]       acc_q, acc_nxt;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;
  logic                   rise;
  logic                   start_run;
  logic                   warm_end, gate_end;

  // RO_in is asynchronous: plain flop chain, then a history flop for edge detect.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      hist_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], RO_in};
      hist_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign rise     = sync_q[SYNC_STAGES-1] & ~hist_q;
  assign warm_end = (phase_q == W_LAST);
  assign gate_end = (phase_q == G_LAST);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; Start only matters when no measurement is running.
  always_comb begin
    state_d   = state_q;
    start_run = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (Start) begin
          state_d   = WARMUP;
          start_run = 1'b1;
        end
      end
      WARMUP:  if (warm_end) state_d = MEASURE;
      MEASURE: if (gate_end) state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  assign Busy = (state_q == WARMUP) || (state_q == MEASURE);
  assign Done = (state_q == DONE);

`ifdef RO_METER_SATURATE_EN
  logic acc_full, sat_hit, sat_q, ovf_q;

  // Saturating accumulate: an edge arriving at all-ones is remembered, not added.
  always_comb begin
    acc_full = &acc_q;
    sat_hit  = rise & acc_full;
    acc_nxt  = (rise && !acc_full) ? acc_q + 1'b1 : acc_q;
  end

  // Sticky saturation flag for the running window; published to Overflow at gate close.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sat_q <= 1'b0;
      ovf_q <= 1'b0;
    end else if (start_run) begin
      sat_q <= 1'b0;
      ovf_q <= 1'b0;
    end else if (state_q == MEASURE) begin
      sat_q <= sat_q | sat_hit;
      if (gate_end) ovf_q <= sat_q | sat_hit;
    end
  end

  assign Overflow = ovf_q;
`else
  // Wrapping accumulate modulo 2^CNT_W.
  always_comb begin
    acc_nxt = acc_q + CNT_W'(rise);
  end

  assign Overflow = 1'b0;
`endif

  // Phase counter, accumulator, ring enable and result latch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q   <= '0;
      acc_q     <= '0;
      Count     <= '0;
      RO_enable <= 1'b0;
    end else if (start_run) begin
      phase_q   <= '0;
      acc_q     <= '0;
      RO_enable <= 1'b1;
    end else begin
      case (state_q)
        WARMUP: phase_q <= warm_end ? '0 : phase_q + 1'b1;
        MEASURE: begin
          acc_q <= acc_nxt;
          if (gate_end) begin
            // acc_nxt already folds in an edge seen in this last gate cycle.
            phase_q   <= '0;
            Count     <= acc_nxt;
            RO_enable <= 1'b0;
          end else begin
            phase_q <= phase_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ro_freq_meter.sv
// Scoreboard bench for ro_freq_meter: each Start pushes its expected result,
// a negedge monitor pops and checks when Done rises.
module tb_ro_freq_meter;
  localparam int W  = 16;
  localparam int G  = 100;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          Start = 1'b0;
  logic          RO_in = 1'b0;
  logic          RO_enable;
  logic [CW-1:0] Count;
  logic          Busy;
  logic          Done;
  logic          Overflow;

  ro_freq_meter #(
    .GATE_CYCLES  (G),
    .WARMUP_CYCLES(W),
    .CNT_W        (CW),
    .SYNC_STAGES  (2)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .Start    (Start),
    .RO_in    (RO_in),
    .RO_enable(RO_enable),
    .Count    (Count),
    .Busy     (Busy),
    .Done     (Done),
    .Overflow (Overflow)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int exp_cnt;
    int tol;
    int exp_ovf;
    int start_cyc;
    bit hold_chk;
    int hold_val;
  } exp_t;
  exp_t sb[$];

  // Ring model: constant level when ro_half==0, else toggles every ro_half clk while enabled.
  int   ro_half  = 0;
  logic ro_level = 1'b0;
  initial begin
    int ro_cnt;
    ro_cnt = 0;
    forever begin
      @(negedge clk);
      if (ro_half == 0) begin
        RO_in  = ro_level;
        ro_cnt = 0;
      end else if (RO_enable) begin
        ro_cnt++;
        if (ro_cnt >= ro_half) begin
          RO_in  = ~RO_in;
          ro_cnt = 0;
        end
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp, input int tol);
    int d;
    checks++;
    d = act - exp;
    if (d < 0) d = -d;
    if (d > tol) begin
      errors++;
      $display("FAIL %s got %0d want %0d (+/-%0d) at cyc %0d", name, act, exp, tol, cyc);
    end
  endtask

  // Monitor: tracks the Busy window and compares on each Done rising edge.
  initial begin
    bit   busy_d, done_d, hold_bad, ovf_bad;
    int   busy_first, busy_len;
    exp_t e;
    busy_d = 0; done_d = 0; hold_bad = 0; ovf_bad = 0;
    busy_first = 0; busy_len = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        busy_d = 0; done_d = 0; hold_bad = 0; ovf_bad = 0;
      end else begin
        if (Busy) begin
          if (!busy_d) begin
            busy_first = cyc; busy_len = 0; hold_bad = 0; ovf_bad = 0;
          end
          busy_len++;
          if (sb.size() > 0 && sb[0].hold_chk && int'(Count) != sb[0].hold_val) hold_bad = 1;
          if (Overflow) ovf_bad = 1;
        end
        if (Done && !done_d) begin
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done got Done=1 want no Done at cyc %0d", cyc);
          end else begin
            e = sb.pop_front();
            chk("count",          int'(Count),     e.exp_cnt, e.tol);
            chk("overflow",       int'(Overflow),  e.exp_ovf, 0);
            chk("busy_start",     busy_first - e.start_cyc, 1, 0);
            chk("done_latency",   cyc - e.start_cyc, W + G + 1, 0);
            chk("busy_len",       busy_len, W + G, 0);
            chk("ro_enable_off",  int'(RO_enable), 0, 0);
            chk("ovf_clear_busy", int'(ovf_bad),   0, 0);
            if (e.hold_chk) chk("count_hold", int'(hold_bad), 0, 0);
          end
        end
        busy_d = Busy;
        done_d = Done;
      end
    end
  end

  task automatic start_run(input int cnt, input int tol, input int ovf,
                           input bit hc, input int hv);
    exp_t e;
    @(negedge clk);
    Start = 1'b1;
    e.exp_cnt = cnt; e.tol = tol; e.exp_ovf = ovf;
    e.start_cyc = cyc; e.hold_chk = hc; e.hold_val = hv;
    sb.push_back(e);
    @(negedge clk);
    Start = 1'b0;
  endtask

  task automatic wait_done(input int limit);
    int n;
    n = 0;
    while (!Done && n < limit) begin
      @(negedge clk);
      n++;
    end
    if (!Done) begin
      checks++;
      errors++;
      $display("FAIL done_timeout got Done=0 want Done=1 within %0d cycles", limit);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got no finish want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state.
    repeat (3) @(negedge clk);
    chk("rst_busy",      int'(Busy),      0, 0);
    chk("rst_done",      int'(Done),      0, 0);
    chk("rst_ro_enable", int'(RO_enable), 0, 0);
    chk("rst_count",     int'(Count),     0, 0);
    chk("rst_overflow",  int'(Overflow),  0, 0);
    rst_n = 1'b1;

    // R1: constant-high ring, Start around cycle 10 -> no edges, exact timing.
    ro_half = 0; ro_level = 1'b1;
    repeat (9) @(negedge clk);
    start_run(0, 0, 0, 1'b1, 0);
    wait_done(W + G + 20);

    // R2: Start from DONE, toggle every 5 -> 10 edges; Start re-pulsed mid-MEASURE.
    ro_level = 1'b0; ro_half = 5;
    start_run(10, 1, 0, 1'b1, 0);
    repeat (60) @(negedge clk);
    Start = 1'b1;
    @(negedge clk);
    Start = 1'b0;
    wait_done(W + G + 20);

    // R3: toggle every 2 -> 25 edges into a 4-bit counter.
    ro_half = 2;
`ifdef RO_METER_SATURATE_EN
    start_run(15, 0, 1, 1'b0, 0);
`else
    start_run(9, 1, 0, 1'b0, 0);
`endif
    wait_done(W + G + 20);

    // R4: constant high again -> 0 edges, Overflow must drop on Start.
    ro_half = 0; ro_level = 1'b1;
    start_run(0, 0, 0, 1'b0, 0);
    wait_done(W + G + 20);

    // R5: toggle every 5 again, Count held at 0 while running.
    ro_level = 1'b0; ro_half = 5;
    start_run(10, 1, 0, 1'b1, 0);
    wait_done(W + G + 20);

    // R6: reset mid-MEASURE discards the run.
    start_run(10, 1, 0, 1'b0, 0);
    repeat (50) @(negedge clk);
    rst_n = 1'b0;
    sb.delete();
    #1;
    chk("midrst_busy",      int'(Busy),      0, 0);
    chk("midrst_done",      int'(Done),      0, 0);
    chk("midrst_ro_enable", int'(RO_enable), 0, 0);
    chk("midrst_count",     int'(Count),     0, 0);
    chk("midrst_overflow",  int'(Overflow),  0, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (30) @(negedge clk);
    chk("post_rst_busy",      int'(Busy),      0, 0);
    chk("post_rst_done",      int'(Done),      0, 0);
    chk("post_rst_ro_enable", int'(RO_enable), 0, 0);
    chk("post_rst_count",     int'(Count),     0, 0);

    // R7: normal run after reset.
    start_run(10, 1, 0, 1'b1, 0);
    wait_done(W + G + 20);

    repeat (5) @(negedge clk);
    chk("sb_empty", sb.size(), 0, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
